cg_memory_arbiter: RTL and testbench
====================================

CG_MEMORY_ARBITER -- requirements
Module: cg_memory_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
REQ-003 SHALL have parameter NUM_REQ, default 2, range 2..8, meaning requester count.
REQ-004 SHALL have parameter TAG_DEPTH, default 4, power of two, meaning outstanding-read capacity.
REQ-005 SHALL have port i_clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_req_raddr_valid  in  NUM_REQ  per-requester read request.
REQ-008 SHALL have port o_req_raddr_ready  out  NUM_REQ  one-hot read grant.
REQ-009 SHALL have port i_req_raddr  in  NUM_REQ*ADDR_WIDTH  packed read addresses.
REQ-010 SHALL have port o_req_rdata_valid  out  NUM_REQ  one-hot read response valid.
REQ-011 SHALL have port i_req_rdata_ready  in  NUM_REQ  per-requester response ready.
REQ-012 SHALL have port o_req_rdata  out  DATA_WIDTH  response data, broadcast to all requesters.
REQ-013 SHALL have port i_req_wvalid  in  NUM_REQ  per-requester write request.
REQ-014 SHALL have port o_req_wready  out  NUM_REQ  one-hot write grant.
REQ-015 SHALL have port i_req_waddr / i_req_wdata  in  NUM_REQ*ADDR_WIDTH / NUM_REQ*DATA_WIDTH  packed write address and data.
REQ-016 SHALL have port o_mem_raddr_valid / i_mem_raddr_ready / o_mem_raddr  out / in / out  1 / 1 / ADDR_WIDTH  memory read address channel.
REQ-017 SHALL have port i_mem_rdata_valid / o_mem_rdata_ready / i_mem_rdata  in / out / in  1 / 1 / DATA_WIDTH  memory read data channel.
REQ-018 SHALL have port o_mem_wen, o_mem_wdata_valid / i_mem_wdata_ready / o_mem_waddr, o_mem_wdata  out / in / out  1 / 1 / ADDR_WIDTH, DATA_WIDTH  memory write channel; wen equals wdata_valid.

Function
REQ-019 Read arbitration SHALL be round-robin: the search starts at rd_ptr, and the first requester with raddr_valid wins.
REQ-020 Grant (o_req_raddr_ready[w]) SHALL assert only when i_mem_raddr_ready=1 and tag count < TAG_DEPTH; o_mem_raddr_valid = any valid AND count < TAG_DEPTH; o_mem_raddr = winner's address; zero-cycle combinational path.
REQ-021 On accepted read handshake, the arbiter SHALL push winner index into the tag FIFO and set rd_ptr = (w+1) mod NUM_REQ.
REQ-022 Response SHALL route to the head tag: o_req_rdata_valid[head] = i_mem_rdata_valid AND not empty; o_mem_rdata_ready = empty ? 1 : i_req_rdata_ready[head]; pop on i_mem_rdata_valid AND o_mem_rdata_ready AND not empty.
REQ-023 Responses arriving with an empty FIFO SHALL be accepted and discarded; no requester sees valid.
REQ-024 A full FIFO SHALL block new grants even if a pop occurs the same cycle; simultaneous push+pop when not full leaves count unchanged.
REQ-025 Write arbitration SHALL use an independent round-robin pointer wr_ptr, advanced on i_mem_wdata_ready AND o_mem_wdata_valid; read and write channels never block each other.
REQ-026 Pointers SHALL not move when no handshake occurs; grants SHALL be stable while i_mem_*_ready is low.
REQ-027 The arbiter SHALL never reorder responses; per-requester and global read order equal issue order.

Reset
REQ-028 While i_rst=1: rd_ptr=wr_ptr=0, tag FIFO empty, and all o_*valid, o_*ready, and o_mem_wen outputs forced 0; data outputs don't-care.
REQ-029 Reset mid-transaction SHALL discard outstanding tags; memory responses after reset are handled per REQ-023.

Configuration
REQ-030 With CG_MEM_ARB_FIXED_PRIO_EN defined, both channels SHALL use fixed priority (lowest index wins) and pointers are not implemented; without it, round-robin per REQ-019/025.

Structure
REQ-031 Package cg_memory_arbiter_pkg SHALL hold the requester-index typedef (width $clog2(NUM_REQ)) and the ptr-advance function.
REQ-032 Sub-module cg_rr_arbiter (request vector, pointer, advance enable -> one-hot grant) SHALL be instantiated once per channel; the tag FIFO is inline.

Verification
REQ-033 NUM_REQ=2, both raddr_valid held, mem ready=1 -> grants alternate 0,1,0,1; responses route one cycle later to matching requester.
REQ-034 Requester 0 issues 4 reads with i_req_rdata_ready=0 and a stalled memory -> 5th request not granted until a pop; count never exceeds 4.
REQ-035 Simultaneous read by req1 and write by req0 to addr 0x10 -> both granted same cycle; read returns pre-write data.
REQ-036 i_rst asserted with 3 reads outstanding -> all outputs 0 next cycle; late i_mem_rdata_valid discarded, no o_req_rdata_valid.
REQ-037 CG_MEM_ARB_FIXED_PRIO_EN defined, both requesters always valid -> requester 0 granted every cycle, requester 1 never.

Source files
------------

// File: rtl/cg_memory_arbiter_pkg.sv
// Shared types and helpers for the cg_memory_arbiter slice.
// Requester indices are sized for the largest supported requester count (8).
package cg_memory_arbiter_pkg;

  localparam int REQ_MAX = 8;
  localparam int IDX_W   = $clog2(REQ_MAX);

  typedef logic [IDX_W-1:0] req_idx_t;

  // Round-robin successor of a winning index, wrapping at the requester count.
  function automatic req_idx_t ptr_advance(input req_idx_t cur, input int num_req);
    req_idx_t nxt_s;
    nxt_s = (int'(cur) >= num_req - 1) ? req_idx_t'(0) : cur + req_idx_t'(1);
    return nxt_s;
  endfunction

endpackage

// File: rtl/cg_rr_arbiter.sv
// Single-channel arbiter: request vector + advance enable -> one-hot grant.
// CG_MEM_ARB_FIXED_PRIO_EN removes the pointer and makes the lowest index win.
module cg_rr_arbiter
  import cg_memory_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv_en,
  output logic [NUM_REQ-1:0] grant,
  output req_idx_t           grant_idx,
  output logic               any_req
);

  req_idx_t ptr_s;
  int       best_d_s;
  int       dist_s;
  logic     take_s;

`ifdef CG_MEM_ARB_FIXED_PRIO_EN
  logic arb_unused_s;
  assign ptr_s        = '0;
  assign arb_unused_s = ^{clk, rst, adv_en};
`else
  req_idx_t ptr_r;

  // Pointer moves past the winner only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (adv_en) begin
      ptr_r <= ptr_advance(grant_idx, NUM_REQ);
    end
  end

  assign ptr_s = ptr_r;
`endif

  // Winner is the active requester closest to the pointer going upward.
  always_comb begin
    grant_idx = '0;
    best_d_s  = NUM_REQ;
    dist_s    = 0;
    take_s    = 1'b0;
    any_req   = |req;
    for (int j = 0; j < NUM_REQ; j++) begin
      dist_s    = (j + NUM_REQ - int'(ptr_s)) % NUM_REQ;
      take_s    = req[j] && (dist_s < best_d_s);
      best_d_s  = take_s ? dist_s : best_d_s;
      grant_idx = take_s ? req_idx_t'(j) : grant_idx;
    end
  end

  // One-hot expansion of the winning index.
  always_comb begin
    grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      grant[j] = any_req && (grant_idx == req_idx_t'(j));
    end
  end

endmodule

// File: rtl/cg_memory_arbiter.sv
// N-requester arbiter onto one memory port with independent read/write channels and
// an in-order read tag FIFO. Define CG_MEM_ARB_FIXED_PRIO_EN for fixed priority.
module cg_memory_arbiter
  import cg_memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_raddr_valid,
  output logic [NUM_REQ-1:0]            o_req_raddr_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_raddr,
  output logic [NUM_REQ-1:0]            o_req_rdata_valid,
  input  logic [NUM_REQ-1:0]            i_req_rdata_ready,
  output logic [DATA_WIDTH-1:0]         o_req_rdata,
  input  logic [NUM_REQ-1:0]            i_req_wvalid,
  output logic [NUM_REQ-1:0]            o_req_wready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_waddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic                          o_mem_raddr_valid,
  input  logic                          i_mem_raddr_ready,
  output logic [ADDR_WIDTH-1:0]         o_mem_raddr,
  input  logic                          i_mem_rdata_valid,
  output logic                          o_mem_rdata_ready,
  input  logic [DATA_WIDTH-1:0]         i_mem_rdata,
  output logic                          o_mem_wen,
  output logic                          o_mem_wdata_valid,
  input  logic                          i_mem_wdata_ready,
  output logic [ADDR_WIDTH-1:0]         o_mem_waddr,
  output logic [DATA_WIDTH-1:0]         o_mem_wdata
);

  localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W  = TAG_AW + 1;

  logic [NUM_REQ-1:0] rd_grant_s;
  logic [NUM_REQ-1:0] wr_grant_s;
  req_idx_t           rd_idx_s;
  req_idx_t           wr_idx_unused_s;
  logic               rd_any_s;
  logic               wr_any_s;

  req_idx_t           tag_mem_r [TAG_DEPTH];
  logic [TAG_AW-1:0]  tag_head_r;
  logic [TAG_AW-1:0]  tag_tail_r;
  logic [CNT_W-1:0]   tag_cnt_r;
  logic               tag_full_s;
  logic               tag_empty_s;
  req_idx_t           head_idx_s;
  logic               head_ready_s;
  logic               push_s;
  logic               pop_s;
  logic               wr_adv_s;

  cg_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk       (i_clk),
    .rst       (i_rst),
    .req       (i_req_raddr_valid),
    .adv_en    (push_s),
    .grant     (rd_grant_s),
    .grant_idx (rd_idx_s),
    .any_req   (rd_any_s)
  );

  cg_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk       (i_clk),
    .rst       (i_rst),
    .req       (i_req_wvalid),
    .adv_en    (wr_adv_s),
    .grant     (wr_grant_s),
    .grant_idx (wr_idx_unused_s),
    .any_req   (wr_any_s)
  );

  assign tag_full_s  = (tag_cnt_r == CNT_W'(TAG_DEPTH));
  assign tag_empty_s = (tag_cnt_r == CNT_W'(0));
  assign head_idx_s  = tag_mem_r[tag_head_r];

  // A full tag FIFO stalls the read address channel regardless of a same-cycle pop.
  assign o_mem_raddr_valid = !i_rst && rd_any_s && !tag_full_s;
  assign o_req_raddr_ready = (!i_rst && i_mem_raddr_ready && !tag_full_s) ? rd_grant_s : '0;
  assign push_s            = o_mem_raddr_valid && i_mem_raddr_ready;

  // Address and data muxes driven by the one-hot grants.
  always_comb begin
    o_mem_raddr = '0;
    o_mem_waddr = '0;
    o_mem_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      o_mem_raddr = rd_grant_s[j] ? i_req_raddr[j*ADDR_WIDTH +: ADDR_WIDTH] : o_mem_raddr;
      o_mem_waddr = wr_grant_s[j] ? i_req_waddr[j*ADDR_WIDTH +: ADDR_WIDTH] : o_mem_waddr;
      o_mem_wdata = wr_grant_s[j] ? i_req_wdata[j*DATA_WIDTH +: DATA_WIDTH] : o_mem_wdata;
    end
  end

  // Responses go to the oldest outstanding tag; with no tag they are sunk silently.
  always_comb begin
    head_ready_s      = 1'b0;
    o_req_rdata_valid = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      head_ready_s         = (head_idx_s == req_idx_t'(j)) ? i_req_rdata_ready[j] : head_ready_s;
      o_req_rdata_valid[j] = (head_idx_s == req_idx_t'(j)) && i_mem_rdata_valid
                             && !tag_empty_s && !i_rst;
    end
  end

  assign o_mem_rdata_ready = !i_rst && (tag_empty_s || head_ready_s);
  assign pop_s             = i_mem_rdata_valid && o_mem_rdata_ready && !tag_empty_s;
  assign o_req_rdata       = i_mem_rdata;

  // Tag FIFO pointers and occupancy; reset drops every outstanding tag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_head_r <= '0;
      tag_tail_r <= '0;
      tag_cnt_r  <= '0;
    end else begin
      if (push_s) begin
        tag_tail_r <= tag_tail_r + TAG_AW'(1);
      end
      if (pop_s) begin
        tag_head_r <= tag_head_r + TAG_AW'(1);
      end
      tag_cnt_r <= tag_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Tag storage holds the issuing requester index.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      tag_mem_r[tag_tail_r] <= rd_idx_s;
    end
  end

  assign o_mem_wdata_valid = !i_rst && wr_any_s;
  assign o_mem_wen         = o_mem_wdata_valid;
  assign o_req_wready      = (!i_rst && i_mem_wdata_ready) ? wr_grant_s : '0;
  assign wr_adv_s          = o_mem_wdata_valid && i_mem_wdata_ready;

endmodule

// File: tb/tb_cg_memory_arbiter.sv
// Scoreboard bench for cg_memory_arbiter: a reference arbitration model plus a
// behavioural one-cycle-latency memory; expected read responses are queued at issue.
module tb_cg_memory_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 2;
  localparam int TD = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [NR-1:0]    i_req_raddr_valid;
  logic [NR-1:0]    o_req_raddr_ready;
  logic [NR*AW-1:0] i_req_raddr;
  logic [NR-1:0]    o_req_rdata_valid;
  logic [NR-1:0]    i_req_rdata_ready;
  logic [DW-1:0]    o_req_rdata;
  logic [NR-1:0]    i_req_wvalid;
  logic [NR-1:0]    o_req_wready;
  logic [NR*AW-1:0] i_req_waddr;
  logic [NR*DW-1:0] i_req_wdata;
  logic             o_mem_raddr_valid;
  logic             i_mem_raddr_ready;
  logic [AW-1:0]    o_mem_raddr;
  logic             i_mem_rdata_valid;
  logic             o_mem_rdata_ready;
  logic [DW-1:0]    i_mem_rdata;
  logic             o_mem_wen;
  logic             o_mem_wdata_valid;
  logic             i_mem_wdata_ready;
  logic [AW-1:0]    o_mem_waddr;
  logic [DW-1:0]    o_mem_wdata;

  cg_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_raddr_valid(i_req_raddr_valid), .o_req_raddr_ready(o_req_raddr_ready),
    .i_req_raddr(i_req_raddr), .o_req_rdata_valid(o_req_rdata_valid),
    .i_req_rdata_ready(i_req_rdata_ready), .o_req_rdata(o_req_rdata),
    .i_req_wvalid(i_req_wvalid), .o_req_wready(o_req_wready),
    .i_req_waddr(i_req_waddr), .i_req_wdata(i_req_wdata),
    .o_mem_raddr_valid(o_mem_raddr_valid), .i_mem_raddr_ready(i_mem_raddr_ready),
    .o_mem_raddr(o_mem_raddr), .i_mem_rdata_valid(i_mem_rdata_valid),
    .o_mem_rdata_ready(o_mem_rdata_ready), .i_mem_rdata(i_mem_rdata),
    .o_mem_wen(o_mem_wen), .o_mem_wdata_valid(o_mem_wdata_valid),
    .i_mem_wdata_ready(i_mem_wdata_ready), .o_mem_waddr(o_mem_waddr),
    .o_mem_wdata(o_mem_wdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       exp_q[$];
  logic [DW-1:0] resp_q[$];
  logic [DW-1:0] mem [256];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            m_rd_ptr = 0;
  int            m_wr_ptr = 0;
  logic          mem_stall;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic int next_ptr(input int w);
`ifdef CG_MEM_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (w + 1) % NR;
`endif
  endfunction

  // Reference model evaluated just before the rising edge.
  task automatic sample();
    logic [NR-1:0] exp_g;
    logic [NR-1:0] exp_v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            w;
    bit            full;
    rd_exp_t       hd;
    if (i_rst) begin
      check_eq("rst_mem_raddr_valid", o_mem_raddr_valid, 0);
      check_eq("rst_req_raddr_ready", o_req_raddr_ready, 0);
      check_eq("rst_req_rdata_valid", o_req_rdata_valid, 0);
      check_eq("rst_mem_rdata_ready", o_mem_rdata_ready, 0);
      check_eq("rst_mem_wdata_valid", o_mem_wdata_valid, 0);
      check_eq("rst_mem_wen", o_mem_wen, 0);
      check_eq("rst_req_wready", o_req_wready, 0);
      exp_q.delete();
      m_rd_ptr = 0;
      m_wr_ptr = 0;
      return;
    end
    full = (exp_q.size() >= TD);
    check_eq("mem_raddr_valid", o_mem_raddr_valid, (|i_req_raddr_valid) && !full);
    w     = rr_pick(i_req_raddr_valid, m_rd_ptr);
    exp_g = '0;
    if (w >= 0 && !full && i_mem_raddr_ready) exp_g[w] = 1'b1;
    check_eq("req_raddr_ready", o_req_raddr_ready, exp_g);
    a = '0;
    if (w >= 0) a = i_req_raddr[w*AW +: AW];
    if (w >= 0 && !full) check_eq("mem_raddr", o_mem_raddr, a);
    if (exp_q.size() > 0) begin
      hd            = exp_q[0];
      exp_v         = '0;
      exp_v[hd.idx] = i_mem_rdata_valid;
      check_eq("req_rdata_valid", o_req_rdata_valid, exp_v);
      check_eq("mem_rdata_ready", o_mem_rdata_ready, i_req_rdata_ready[hd.idx]);
      if (i_mem_rdata_valid && i_req_rdata_ready[hd.idx]) begin
        check_eq("req_rdata", o_req_rdata, hd.data);
        void'(exp_q.pop_front());
        void'(resp_q.pop_front());
      end
    end else begin
      check_eq("idle_rdata_valid", o_req_rdata_valid, 0);
      check_eq("idle_rdata_ready", o_mem_rdata_ready, 1);
      if (i_mem_rdata_valid) void'(resp_q.pop_front());
    end
    if (exp_g != '0) begin
      exp_q.push_back('{idx: w, data: mem[a[7:0]]});
      resp_q.push_back(mem[a[7:0]]);
      m_rd_ptr = next_ptr(w);
    end
    w = rr_pick(i_req_wvalid, m_wr_ptr);
    check_eq("mem_wdata_valid", o_mem_wdata_valid, w >= 0);
    check_eq("mem_wen", o_mem_wen, w >= 0);
    exp_g = '0;
    if (w >= 0 && i_mem_wdata_ready) exp_g[w] = 1'b1;
    check_eq("req_wready", o_req_wready, exp_g);
    if (w >= 0) begin
      a = i_req_waddr[w*AW +: AW];
      d = i_req_wdata[w*DW +: DW];
      check_eq("mem_waddr", o_mem_waddr, a);
      check_eq("mem_wdata", o_mem_wdata, d);
      if (i_mem_wdata_ready) begin
        mem[a[7:0]] = d;
        m_wr_ptr    = next_ptr(w);
      end
    end
  endtask

  task automatic step();
    i_mem_rdata_valid = !mem_stall && (resp_q.size() > 0);
    i_mem_rdata       = (resp_q.size() > 0) ? resp_q[0] : '0;
    #3;
    sample();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic rand_addrs();
    for (int j = 0; j < NR; j++) begin
      i_req_raddr[j*AW +: AW] = AW'($urandom_range(0, 255));
      i_req_waddr[j*AW +: AW] = AW'($urandom_range(0, 255));
      i_req_wdata[j*DW +: DW] = DW'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[16]           = 32'h1234_5678;
    i_rst             = 1'b1;
    i_req_raddr_valid = '0;
    i_req_rdata_ready = '0;
    i_req_wvalid      = '0;
    i_req_raddr       = '0;
    i_req_waddr       = '0;
    i_req_wdata       = '0;
    i_mem_raddr_ready = 1'b1;
    i_mem_wdata_ready = 1'b1;
    mem_stall         = 1'b0;
    i_mem_rdata_valid = 1'b0;
    i_mem_rdata       = '0;
    @(negedge i_clk);
    repeat (2) step();
    i_rst = 1'b0;

    // Both requesters streaming reads: alternating grants, responses next cycle.
    i_req_raddr_valid = 2'b11;
    i_req_rdata_ready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      rand_addrs();
      step();
    end
    i_req_raddr_valid = 2'b00;
    repeat (3) step();

    // Tag capacity: four reads outstanding, fifth held until a pop.
    mem_stall         = 1'b1;
    i_req_rdata_ready = 2'b00;
    i_req_raddr_valid = 2'b01;
    repeat (7) begin
      rand_addrs();
      step();
    end
    mem_stall = 1'b0;
    repeat (2) step();
    i_req_rdata_ready = 2'b11;
    repeat (2) step();
    i_req_raddr_valid = 2'b00;
    repeat (6) step();

    // Same-cycle read (req1) and write (req0) of address 0x10.
    i_req_raddr[1*AW +: AW] = 32'h10;
    i_req_waddr[0*AW +: AW] = 32'h10;
    i_req_wdata[0*DW +: DW] = 32'hDEAD_BEEF;
    i_req_raddr_valid       = 2'b10;
    i_req_wvalid            = 2'b01;
    step();
    i_req_raddr_valid = 2'b00;
    i_req_wvalid      = 2'b00;
    repeat (3) step();

    // Reset with three reads outstanding; late responses must be swallowed.
    mem_stall         = 1'b1;
    i_req_raddr_valid = 2'b11;
    repeat (3) begin
      rand_addrs();
      step();
    end
    i_req_raddr_valid = 2'b00;
    i_rst             = 1'b1;
    step();
    i_rst     = 1'b0;
    mem_stall = 1'b0;
    repeat (5) step();

    // Randomised traffic on both channels with backpressure everywhere.
    repeat (80) begin
      rand_addrs();
      i_req_raddr_valid = NR'($urandom);
      i_req_wvalid      = NR'($urandom);
      i_req_rdata_ready = NR'($urandom);
      i_mem_raddr_ready = 1'($urandom);
      i_mem_wdata_ready = 1'($urandom);
      mem_stall         = ($urandom_range(0, 3) == 0);
      step();
    end
    i_req_raddr_valid = '0;
    i_req_wvalid      = '0;
    i_req_rdata_ready = '1;
    mem_stall         = 1'b0;
    repeat (10) step();
    check_eq("drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
